ahb_slave_mux: RTL and testbench
================================

Name: ahb_slave_mux

Overview:
- Data-phase response multiplexer for the Cortex-M3 AHB-Lite system bus.
- Sits directly downstream of the system address decoder. It consumes MUX_SEL and HSEL_NO_MAP from the address phase and routes the selected slave's HRDATA/HREADYOUT/HRESP back to the master during the data phase.
- Contains the built-in default slave. The default slave returns a two-cycle AHB ERROR response for active transfers to unmapped addresses, and keeps a saturating count of those errors.

Parameters:
- DFLT_RDATA, 32'h0000_0000, HRDATA value driven while the default slave owns the data phase.
- ERR_CNT_W, 8, width of the saturating unmapped-access error counter.

Ports:
- HCLK  input  1  system bus clock; all state updates on its rising edge.
- HRESET  input  1  asynchronous, active-high reset.
- HTRANS  input  2  master transfer type; bit 1 set means NONSEQ/SEQ.
- HSEL_NO_MAP  input  1  decoder: address-phase address is unmapped.
- MUX_SEL  input  3  decoder slave index: 000..110 = S0..S6, 111 = default slave.
- HRDATA_S0..HRDATA_S6  input  32 each  slave read data.
- HREADYOUT_S0..HREADYOUT_S6  input  1 each  slave ready.
- HRESP_S0..HRESP_S6  input  1 each  slave response; 0 = OKAY, 1 = ERROR.
- HRDATA  output  32  muxed read data to the master.
- HREADY  output  1  muxed ready; this is the system HREADY, fed back to all slaves and used internally.
- HRESP  output  1  muxed response.
- ERR_CNT  output  ERR_CNT_W  count of ERROR responses issued by the default slave.

Behaviour:
- Reset, asynchronous on HRESET high:
  - sel_q = 3'b111; default-slave FSM = DS_IDLE; ERR_CNT = 0.
  - Resulting outputs: HREADY = 1, HRESP = 0, HRDATA = DFLT_RDATA.
- Select register:
  - sel_q <= MUX_SEL on any rising edge where HREADY = 1.
  - sel_q holds while HREADY = 0, so a wait-stated data phase keeps its slave.
- Output mux (combinational on sel_q):
  - sel_q 000..110: HRDATA/HREADY/HRESP come from the corresponding S0..S6 inputs.
  - sel_q 111: outputs come from the default slave.
  - No extra latency; the response is visible in the same cycle the slave drives it.
- Default slave FSM, states DS_IDLE, DS_ERR1, DS_ERR2:
  - DS_IDLE:
    - Outputs ready = 1, resp = 0 (OKAY).
    - Go to DS_ERR1 when HREADY & HSEL_NO_MAP & HTRANS[1]; otherwise stay.
  - DS_ERR1:
    - Outputs ready = 0, resp = 1.
    - Go to DS_ERR2 unconditionally.
  - DS_ERR2:
    - Outputs ready = 1, resp = 1.
    - Go to DS_ERR1 if HSEL_NO_MAP & HTRANS[1] (back-to-back unmapped access); otherwise go to DS_IDLE.
  - Default-slave HRDATA is always DFLT_RDATA.
- IDLE/BUSY transfers (HTRANS[1] = 0) to an unmapped address never enter DS_ERR1. They get a zero-wait OKAY response.
- A mapped address phase that is accepted during DS_ERR2 returns the FSM to DS_IDLE. The next data phase is then served by that slave via sel_q.
- ERR_CNT:
  - Increments by 1 on each DS_IDLE->DS_ERR1 or DS_ERR2->DS_ERR1 transition.
  - Saturates at all-ones (255 at the default width) and never wraps.
- Simultaneous events: HRESET overrides every transition. Reset asserted mid-error, in DS_ERR1 or DS_ERR2, forces DS_IDLE and HREADY = 1 immediately (asynchronous).
- The FSM advances only on the ready condition above. HREADY is low only in DS_ERR1, which always exits unconditionally, so no deadlock is possible.

Test Plan:
1. Assert HRESET mid-cycle with any inputs -> immediately HREADY = 1, HRESP = 0, HRDATA = 0, ERR_CNT = 0. After release, outputs are unchanged until a slave is selected.
2. Address phase MUX_SEL = 000 with HTRANS = 2'b10; next cycle HRDATA_S0 = 32'hDEAD_BEEF, HREADYOUT_S0 = 1 -> HRDATA = 32'hDEAD_BEEF, HREADY = 1, HRESP = 0 in the data-phase cycle.
3. MUX_SEL = 010, then MUX_SEL changes to 000 while HREADYOUT_S2 = 0 for 3 cycles -> output stays on S2 (HREADY = 0 for 3 cycles). sel_q switches to 000 only after the cycle in which HREADY = 1.
4. HSEL_NO_MAP = 1, MUX_SEL = 111, HTRANS = 2'b10 -> data phase is cycle 1 HREADY = 0, HRESP = 1; cycle 2 HREADY = 1, HRESP = 1; ERR_CNT = 1. The same access with HTRANS = 2'b00 gives HREADY = 1, HRESP = 0 and ERR_CNT unchanged.
5. Two back-to-back unmapped NONSEQ accesses (the second presented during DS_ERR2) -> pattern ERR1, ERR2, ERR1, ERR2 with no DS_IDLE gap; ERR_CNT = 2. Then 300 more unmapped accesses -> ERR_CNT = 255, saturated, with no wrap.
6. Assert HRESET during DS_ERR1 -> HREADY = 1, HRESP = 0 at once, ERR_CNT = 0. After release, a mapped S3 access completes normally.

Source files
------------

// File: rtl/ahb_slave_mux.sv
// AHB-Lite data-phase response multiplexer with a built-in default slave.
// The default slave answers unmapped NONSEQ/SEQ transfers with a two-cycle
// ERROR response and keeps a saturating count of those errors.
module ahb_slave_mux #(
    parameter logic [31:0] DFLT_RDATA = 32'h0000_0000,
    parameter int unsigned ERR_CNT_W  = 8
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic [1:0]           HTRANS,
    input  logic                 HSEL_NO_MAP,
    input  logic [2:0]           MUX_SEL,
    input  logic [31:0]          HRDATA_S0,
    input  logic [31:0]          HRDATA_S1,
    input  logic [31:0]          HRDATA_S2,
    input  logic [31:0]          HRDATA_S3,
    input  logic [31:0]          HRDATA_S4,
    input  logic [31:0]          HRDATA_S5,
    input  logic [31:0]          HRDATA_S6,
    input  logic                 HREADYOUT_S0,
    input  logic                 HREADYOUT_S1,
    input  logic                 HREADYOUT_S2,
    input  logic                 HREADYOUT_S3,
    input  logic                 HREADYOUT_S4,
    input  logic                 HREADYOUT_S5,
    input  logic                 HREADYOUT_S6,
    input  logic                 HRESP_S0,
    input  logic                 HRESP_S1,
    input  logic                 HRESP_S2,
    input  logic                 HRESP_S3,
    input  logic                 HRESP_S4,
    input  logic                 HRESP_S5,
    input  logic                 HRESP_S6,
    output logic [31:0]          HRDATA,
    output logic                 HREADY,
    output logic                 HRESP,
    output logic [ERR_CNT_W-1:0] ERR_CNT
);

    typedef enum logic [1:0] {
        DS_IDLE = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } ds_state_t;

    logic [2:0]           sel_q;
    ds_state_t            ds_state_q;
    logic                 ds_ready_q;
    logic                 ds_resp_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;

    // Only HTRANS[1] distinguishes active transfers from IDLE/BUSY.
    logic unused_htrans0;
    assign unused_htrans0 = HTRANS[0];

    logic unmapped_active;
    logic err_cnt_sat;

    assign unmapped_active = HSEL_NO_MAP & HTRANS[1];
    assign err_cnt_sat     = (err_cnt_q == {ERR_CNT_W{1'b1}});
    assign ERR_CNT         = err_cnt_q;

    // Capture the decoder selection when the address phase is accepted.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            sel_q <= 3'b111;
        end else if (HREADY) begin
            sel_q <= MUX_SEL;
        end
    end

    // Default-slave FSM with registered ready/resp and the saturating error counter.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            ds_state_q <= DS_IDLE;
            ds_ready_q <= 1'b1;
            ds_resp_q  <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            unique case (ds_state_q)
                DS_IDLE: begin
                    if (HREADY && unmapped_active) begin
                        ds_state_q <= DS_ERR1;
                        ds_ready_q <= 1'b0;
                        ds_resp_q  <= 1'b1;
                        if (!err_cnt_sat) begin
                            err_cnt_q <= err_cnt_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                DS_ERR1: begin
                    ds_state_q <= DS_ERR2;
                    ds_ready_q <= 1'b1;
                    ds_resp_q  <= 1'b1;
                end
                DS_ERR2: begin
                    // A second unmapped access accepted here restarts the error
                    // without passing through idle.
                    if (unmapped_active) begin
                        ds_state_q <= DS_ERR1;
                        ds_ready_q <= 1'b0;
                        ds_resp_q  <= 1'b1;
                        if (!err_cnt_sat) begin
                            err_cnt_q <= err_cnt_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        ds_state_q <= DS_IDLE;
                        ds_ready_q <= 1'b1;
                        ds_resp_q  <= 1'b0;
                    end
                end
                default: begin
                    ds_state_q <= DS_IDLE;
                    ds_ready_q <= 1'b1;
                    ds_resp_q  <= 1'b0;
                end
            endcase
        end
    end

    // Route the data-phase owner's response back to the master.
    always_comb begin
        HRDATA = DFLT_RDATA;
        HREADY = ds_ready_q;
        HRESP  = ds_resp_q;
        case (sel_q)
            3'd0: begin HRDATA = HRDATA_S0; HREADY = HREADYOUT_S0; HRESP = HRESP_S0; end
            3'd1: begin HRDATA = HRDATA_S1; HREADY = HREADYOUT_S1; HRESP = HRESP_S1; end
            3'd2: begin HRDATA = HRDATA_S2; HREADY = HREADYOUT_S2; HRESP = HRESP_S2; end
            3'd3: begin HRDATA = HRDATA_S3; HREADY = HREADYOUT_S3; HRESP = HRESP_S3; end
            3'd4: begin HRDATA = HRDATA_S4; HREADY = HREADYOUT_S4; HRESP = HRESP_S4; end
            3'd5: begin HRDATA = HRDATA_S5; HREADY = HREADYOUT_S5; HRESP = HRESP_S5; end
            3'd6: begin HRDATA = HRDATA_S6; HREADY = HREADYOUT_S6; HRESP = HRESP_S6; end
            default: begin
                HRDATA = DFLT_RDATA;
                HREADY = ds_ready_q;
                HRESP  = ds_resp_q;
            end
        endcase
    end

endmodule

// File: tb/tb_ahb_slave_mux.sv
// Self-checking bench for ahb_slave_mux: directed scenarios plus a randomized
// run against a transaction-level model of the data-phase owner and error sequence.
module tb_ahb_slave_mux;

    logic        HCLK;
    logic        HRESET;
    logic [1:0]  HTRANS;
    logic        HSEL_NO_MAP;
    logic [2:0]  MUX_SEL;
    logic [31:0] s_rdata [7];
    logic        s_ready [7];
    logic        s_resp  [7];
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;
    logic [7:0]  ERR_CNT;

    int n_checks = 0;
    int n_errors = 0;

    logic [33:0] obs;
    logic [33:0] exp_v;
    assign obs = {HREADY, HRESP, HRDATA};

    localparam logic [33:0] DFLT_OK = {1'b1, 1'b0, 32'h0};

    ahb_slave_mux dut (
        .HCLK         (HCLK),
        .HRESET       (HRESET),
        .HTRANS       (HTRANS),
        .HSEL_NO_MAP  (HSEL_NO_MAP),
        .MUX_SEL      (MUX_SEL),
        .HRDATA_S0    (s_rdata[0]),
        .HRDATA_S1    (s_rdata[1]),
        .HRDATA_S2    (s_rdata[2]),
        .HRDATA_S3    (s_rdata[3]),
        .HRDATA_S4    (s_rdata[4]),
        .HRDATA_S5    (s_rdata[5]),
        .HRDATA_S6    (s_rdata[6]),
        .HREADYOUT_S0 (s_ready[0]),
        .HREADYOUT_S1 (s_ready[1]),
        .HREADYOUT_S2 (s_ready[2]),
        .HREADYOUT_S3 (s_ready[3]),
        .HREADYOUT_S4 (s_ready[4]),
        .HREADYOUT_S5 (s_ready[5]),
        .HREADYOUT_S6 (s_ready[6]),
        .HRESP_S0     (s_resp[0]),
        .HRESP_S1     (s_resp[1]),
        .HRESP_S2     (s_resp[2]),
        .HRESP_S3     (s_resp[3]),
        .HRESP_S4     (s_resp[4]),
        .HRESP_S5     (s_resp[5]),
        .HRESP_S6     (s_resp[6]),
        .HRDATA       (HRDATA),
        .HREADY       (HREADY),
        .HRESP        (HRESP),
        .ERR_CNT      (ERR_CNT)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic set_idle();
        HTRANS      = 2'b00;
        HSEL_NO_MAP = 1'b0;
        MUX_SEL     = 3'b111;
        for (int i = 0; i < 7; i++) begin
            s_rdata[i] = 32'h5A00_0000 | 32'(i);
            s_ready[i] = 1'b1;
            s_resp[i]  = 1'b0;
        end
    endtask

    task automatic set_unmapped_nonseq();
        HTRANS      = 2'b10;
        HSEL_NO_MAP = 1'b1;
        MUX_SEL     = 3'b111;
    endtask

    task automatic apply_reset();
        @(negedge HCLK);
        HRESET = 1'b1;
        set_idle();
        @(negedge HCLK);
        HRESET = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        HRESET      = 1'b1;
        HTRANS      = 2'b10;
        HSEL_NO_MAP = 1'b1;
        MUX_SEL     = 3'($urandom_range(0, 7));
        #1;
        n_checks++;
        if (obs !== DFLT_OK || ERR_CNT !== 8'd0) begin
            n_errors++;
            $display("FAIL reset_async: got rdy/resp/data=%h cnt=%0d, want %h cnt=0", obs, ERR_CNT, DFLT_OK);
        end
        @(negedge HCLK);
        set_idle();
        @(negedge HCLK);
        HRESET = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (obs !== DFLT_OK || ERR_CNT !== 8'd0) begin
                n_errors++;
                $display("FAIL reset_release[%0d]: got %h cnt=%0d, want %h cnt=0", c, obs, ERR_CNT, DFLT_OK);
            end
            @(negedge HCLK);
        end
    endtask

    task automatic test_mapped_read();
        set_idle();
        MUX_SEL = 3'd0;
        HTRANS  = 2'b10;
        #1;
        n_checks++;
        if (obs !== DFLT_OK) begin
            n_errors++;
            $display("FAIL read_addr_phase: got %h, want %h", obs, DFLT_OK);
        end
        @(negedge HCLK);
        MUX_SEL    = 3'b111;
        HTRANS     = 2'b00;
        s_rdata[0] = 32'hDEAD_BEEF;
        #1;
        n_checks++;
        if (obs !== {1'b1, 1'b0, 32'hDEAD_BEEF}) begin
            n_errors++;
            $display("FAIL read_data_phase: got %h, want %h", obs, {1'b1, 1'b0, 32'hDEAD_BEEF});
        end
        @(negedge HCLK);
        #1;
        n_checks++;
        if (obs !== DFLT_OK) begin
            n_errors++;
            $display("FAIL read_back_to_default: got %h, want %h", obs, DFLT_OK);
        end
        @(negedge HCLK);
    endtask

    task automatic test_wait_state();
        set_idle();
        MUX_SEL = 3'd2;
        HTRANS  = 2'b10;
        @(negedge HCLK);
        MUX_SEL    = 3'd0;
        s_rdata[2] = 32'h2222_1111;
        s_rdata[0] = 32'h0000_AAAA;
        for (int c = 0; c < 4; c++) begin
            s_ready[2] = (c == 3);
            #1;
            exp_v = {(c == 3), 1'b0, 32'h2222_1111};
            n_checks++;
            if (obs !== exp_v) begin
                n_errors++;
                $display("FAIL wait_hold_s2[%0d]: got %h, want %h", c, obs, exp_v);
            end
            @(negedge HCLK);
        end
        MUX_SEL    = 3'b111;
        HTRANS     = 2'b00;
        s_ready[2] = 1'b0;
        #1;
        n_checks++;
        if (obs !== {1'b1, 1'b0, 32'h0000_AAAA}) begin
            n_errors++;
            $display("FAIL wait_switch_s0: got %h, want %h", obs, {1'b1, 1'b0, 32'h0000_AAAA});
        end
        @(negedge HCLK);
        set_idle();
    endtask

    task automatic test_unmapped();
        set_idle();
        set_unmapped_nonseq();
        #1;
        n_checks++;
        if (obs !== DFLT_OK) begin
            n_errors++;
            $display("FAIL unmapped_addr: got %h, want %h", obs, DFLT_OK);
        end
        @(negedge HCLK);
        set_idle();
        #1;
        n_checks++;
        if (obs !== {1'b0, 1'b1, 32'h0}) begin
            n_errors++;
            $display("FAIL unmapped_err1: got %h, want %h", obs, {1'b0, 1'b1, 32'h0});
        end
        @(negedge HCLK);
        #1;
        n_checks++;
        if (obs !== {1'b1, 1'b1, 32'h0} || ERR_CNT !== 8'd1) begin
            n_errors++;
            $display("FAIL unmapped_err2: got %h cnt=%0d, want %h cnt=1", obs, ERR_CNT, {1'b1, 1'b1, 32'h0});
        end
        @(negedge HCLK);
        HSEL_NO_MAP = 1'b1;
        HTRANS      = 2'b00;
        #1;
        n_checks++;
        if (obs !== DFLT_OK) begin
            n_errors++;
            $display("FAIL unmapped_idle_addr: got %h, want %h", obs, DFLT_OK);
        end
        @(negedge HCLK);
        set_idle();
        #1;
        n_checks++;
        if (obs !== DFLT_OK || ERR_CNT !== 8'd1) begin
            n_errors++;
            $display("FAIL unmapped_idle_data: got %h cnt=%0d, want %h cnt=1", obs, ERR_CNT, DFLT_OK);
        end
        @(negedge HCLK);
    endtask

    task automatic test_back_to_back();
        logic [33:0] pat [4];
        int          low_cnt;
        int          wraps;
        logic [7:0]  prev;
        pat[0] = {1'b0, 1'b1, 32'h0};
        pat[1] = {1'b1, 1'b1, 32'h0};
        pat[2] = {1'b0, 1'b1, 32'h0};
        pat[3] = {1'b1, 1'b1, 32'h0};
        apply_reset();
        set_unmapped_nonseq();
        @(negedge HCLK);
        for (int c = 0; c < 4; c++) begin
            if (c == 3) set_idle();
            #1;
            n_checks++;
            if (obs !== pat[c]) begin
                n_errors++;
                $display("FAIL b2b_pattern[%0d]: got %h, want %h", c, obs, pat[c]);
            end
            @(negedge HCLK);
            if (c < 2) set_unmapped_nonseq();
            if (c == 2) set_idle();
        end
        #1;
        n_checks++;
        if (obs !== DFLT_OK || ERR_CNT !== 8'd2) begin
            n_errors++;
            $display("FAIL b2b_count: got %h cnt=%0d, want %h cnt=2", obs, ERR_CNT, DFLT_OK);
        end
        low_cnt = 0;
        wraps   = 0;
        prev    = ERR_CNT;
        set_unmapped_nonseq();
        for (int c = 0; c < 600; c++) begin
            #1;
            if (!HREADY) low_cnt++;
            if (ERR_CNT < prev) wraps++;
            prev = ERR_CNT;
            @(negedge HCLK);
        end
        set_idle();
        #1;
        n_checks++;
        if (low_cnt != 300 || wraps != 0) begin
            n_errors++;
            $display("FAIL sat_stream: got low=%0d wraps=%0d, want low=300 wraps=0", low_cnt, wraps);
        end
        n_checks++;
        if (obs !== {1'b1, 1'b1, 32'h0} || ERR_CNT !== 8'd255) begin
            n_errors++;
            $display("FAIL sat_count: got %h cnt=%0d, want %h cnt=255", obs, ERR_CNT, {1'b1, 1'b1, 32'h0});
        end
        @(negedge HCLK);
        #1;
        n_checks++;
        if (obs !== DFLT_OK || ERR_CNT !== 8'd255) begin
            n_errors++;
            $display("FAIL sat_hold: got %h cnt=%0d, want %h cnt=255", obs, ERR_CNT, DFLT_OK);
        end
        @(negedge HCLK);
    endtask

    task automatic test_reset_mid_error();
        set_idle();
        set_unmapped_nonseq();
        @(negedge HCLK);
        set_idle();
        #1;
        n_checks++;
        if (obs !== {1'b0, 1'b1, 32'h0}) begin
            n_errors++;
            $display("FAIL midrst_in_err1: got %h, want %h", obs, {1'b0, 1'b1, 32'h0});
        end
        #1;
        HRESET = 1'b1;
        #1;
        n_checks++;
        if (obs !== DFLT_OK || ERR_CNT !== 8'd0) begin
            n_errors++;
            $display("FAIL midrst_async: got %h cnt=%0d, want %h cnt=0", obs, ERR_CNT, DFLT_OK);
        end
        @(negedge HCLK);
        HRESET  = 1'b0;
        MUX_SEL = 3'd3;
        HTRANS  = 2'b10;
        @(negedge HCLK);
        MUX_SEL    = 3'b111;
        HTRANS     = 2'b00;
        s_rdata[3] = 32'h3333_CAFE;
        #1;
        n_checks++;
        if (obs !== {1'b1, 1'b0, 32'h3333_CAFE} || ERR_CNT !== 8'd0) begin
            n_errors++;
            $display("FAIL midrst_s3_read: got %h cnt=%0d, want %h cnt=0", obs, ERR_CNT, {1'b1, 1'b0, 32'h3333_CAFE});
        end
        @(negedge HCLK);
        set_idle();
    endtask

    // Model: who owns the data phase, where we are in a two-cycle error, and how
    // many errors have been issued.
    task automatic test_random();
        int owner;
        int err_phase;
        int cnt;
        int ms;
        logic e_ready;
        apply_reset();
        owner     = 7;
        err_phase = 0;
        cnt       = 0;
        for (int c = 0; c < 2000; c++) begin
            ms          = int'($urandom_range(0, 7));
            MUX_SEL     = 3'(ms);
            HSEL_NO_MAP = (ms == 7);
            HTRANS      = 2'($urandom_range(0, 3));
            for (int i = 0; i < 7; i++) begin
                s_rdata[i] = $urandom;
                s_ready[i] = ($urandom_range(0, 3) != 0);
                s_resp[i]  = ($urandom_range(0, 7) == 0);
            end
            if (owner < 7) exp_v = {s_ready[owner], s_resp[owner], s_rdata[owner]};
            else if (err_phase == 1) exp_v = {1'b0, 1'b1, 32'h0};
            else if (err_phase == 2) exp_v = {1'b1, 1'b1, 32'h0};
            else exp_v = DFLT_OK;
            e_ready = exp_v[33];
            #1;
            n_checks++;
            if (obs !== exp_v || ERR_CNT !== 8'(cnt)) begin
                n_errors++;
                $display("FAIL random[%0d]: got %h cnt=%0d, want %h cnt=%0d", c, obs, ERR_CNT, exp_v, cnt);
            end
            if (err_phase == 1) begin
                err_phase = 2;
            end else if (e_ready && ms == 7 && HTRANS[1]) begin
                err_phase = 1;
                if (cnt < 255) cnt++;
            end else begin
                err_phase = 0;
            end
            if (e_ready) owner = ms;
            @(negedge HCLK);
        end
    endtask

    initial begin
        HRESET = 1'b0;
        set_idle();
        test_reset();
        test_mapped_read();
        test_wait_state();
        test_unmapped();
        test_back_to_back();
        test_reset_mid_error();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
